// File: rtl/i3_vector_gen.sv
// Reverse stimulus generator for the i3 reduction block: each emitted 132-bit vector
// is LFSR-random but shaped so that i3 evaluates it to the requested 6-bit code.
module i3_vector_gen #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_target,
  input  logic [7:0]   req_count,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic [131:0] vec_data,
  output logic [5:0]   vec_tag,
  output logic         done,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  state_t         state_q, state_d;
  logic [31:0]    lfsr_q, lfsr_d, lfsr_step;
  logic [2:0]     k_q, k_d;
  logic [127:0]   words_q, words_d;
  logic [7:0]     rem_q, rem_d;
  logic           vec_valid_q, vec_valid_d;
  logic [131:0]   vec_data_q, vec_data_d;
  logic [5:0]     vec_tag_q, vec_tag_d;
  logic           done_q, done_d;
  logic [159:0]   raw;

  // Force each group's OR/AND-of-ORs result: set an even bit to make a pair true,
  // or clear the LFSR-selected pair (all of G0/G1) to make the group false.
  function automatic logic [131:0] build_vector(input logic [159:0] r, input logic [5:0] t);
    logic [131:0] v;
    logic [3:0]   sel;
    int           p;
    v = r[131:0];
    for (int g = 0; g < 2; g++) begin
      if (t[g]) begin
        if (v[2*g +: 2] == 2'b00) v[2*g] = 1'b1;
      end else begin
        v[2*g +: 2] = 2'b00;
      end
    end
    for (int g = 2; g < 6; g++) begin
      sel = r[132 + 4*(g-2) +: 4];
      for (int j = 0; j < 16; j++) begin
        p = 4 + 32*(g-2) + 2*j;
        if (t[g]) begin
          if (v[p +: 2] == 2'b00) v[p] = 1'b1;
        end else if (sel == j[3:0]) begin
          v[p +: 2] = 2'b00;
        end
      end
    end
    return v;
  endfunction

  assign lfsr_step = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign raw       = {lfsr_step, words_q};

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    k_d         = k_q;
    words_d     = words_q;
    rem_d       = rem_q;
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;
    vec_tag_d   = vec_tag_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          vec_tag_d = req_target;
          rem_d     = req_count;
          if (req_count == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_GEN;
            k_d     = 3'd0;
          end
        end
      end
      S_GEN: begin
        lfsr_d = lfsr_step;
        case (k_q)
          3'd0:    words_d[31:0]   = lfsr_step;
          3'd1:    words_d[63:32]  = lfsr_step;
          3'd2:    words_d[95:64]  = lfsr_step;
          3'd3:    words_d[127:96] = lfsr_step;
          default: words_d         = words_q;
        endcase
        // Fifth word goes straight from the stepped LFSR into the build.
        if (k_q == 3'd4) begin
          vec_data_d  = build_vector(raw, vec_tag_q);
          vec_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_OUT: begin
        if (vec_ready) begin
          vec_valid_d = 1'b0;
          rem_d       = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_GEN;
            k_d     = 3'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      k_q         <= 3'd0;
      words_q     <= '0;
      rem_q       <= 8'd0;
      vec_valid_q <= 1'b0;
      vec_data_q  <= '0;
      vec_tag_q   <= 6'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      k_q         <= k_d;
      words_q     <= words_d;
      rem_q       <= rem_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
      vec_tag_q   <= vec_tag_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign vec_tag   = vec_tag_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
